modulation_sampler: RTL and testbench
=====================================

# modulation_sampler

Sequencer feeding the amplitude-modulation path from the dual-segment modulation BRAM. It reads through `MOD_BUS`, advancing one sample per `UPDATE` strobe and wrapping at the per-segment cycle length. It also counts repeats and performs segment transitions, either immediate or deferred to the next wrap. The registered 8-bit sample goes downstream with a one-cycle valid pulse.

## Interface
- `READ_LATENCY`, 2: BRAM address-to-`VALUE` cycles; fixed by the BRAM_MOD configuration.
- `CLK` in 1: system clock; the only clock.
- `RST` in 1: synchronous, active-high reset.
- `UPDATE` in 1: one-cycle strobe; advance by one sample.
- `REQ_VALID` in 1: one-cycle segment-change request.
- `REQ_SEGMENT` in 1: target segment of the request.
- `REQ_MODE` in 1: 0 = immediate, 1 = at next wrap (`params::TRANSITION_IMMEDIATE` / `TRANSITION_SYNC`).
- `CYCLE_0`, `CYCLE_1` in 15: last valid index of each segment (length − 1).
- `REP_0`, `REP_1` in 16: plays − 1 per segment; `16'hFFFF` means infinite.
- `MOD_BUS` modulation_bus_if.out_port: drives `IDX[14:0]` and `SEGMENT`; receives `VALUE[7:0]`.
- `VALUE_OUT` out 8: last fetched sample.
- `VALUE_VALID` out 1: one-cycle pulse when `VALUE_OUT` updates.
- `IDX_OUT` out 15: current index; `SEGMENT_OUT` out 1: current segment.
- `STOPPED` out 1: repeat count exhausted.
- `SYNC_PENDING` out 1: deferred request latched.

## Operation
- Registers:
  - `idx` (15 bits), `seg` (1 bit), `loop_cnt` (16 bits)
  - pending request `{pend, pend_seg}`
  - state ∈ {RUN, STOP}
- `MOD_BUS.IDX` = `idx` and `MOD_BUS.SEGMENT` = `seg`, driven directly from registers.
- RUN, `UPDATE` with `idx >= CYCLE_seg`, i.e. wrap (`>=` covers `CYCLE` shrinking while running). Conditions are checked in this order:
  1. `pend`: `seg <= pend_seg`, `idx <= 0`, `loop_cnt <= 0`, `pend <= 0`.
  2. Else if `REP_seg != FFFF` and `loop_cnt == REP_seg`: go to STOP; `idx` holds at its current value.
  3. Else: `idx <= 0`, `loop_cnt <= loop_cnt + 1`. The counter saturates at FFFF and never wraps.
- RUN, `UPDATE` without wrap: `idx <= idx + 1`.
- STOP: `UPDATE` is ignored. Any `REQ_VALID`, in either mode, acts as immediate and returns to RUN.
- Immediate request: `seg <= REQ_SEGMENT`, `idx <= 0`, `loop_cnt <= 0`, `pend <= 0`, state RUN. A request naming the current segment restarts that segment.
- Sync request in RUN: `pend <= 1`, `pend_seg <= REQ_SEGMENT`. A later request overwrites it; last one wins.
- Simultaneous `REQ_VALID` and `UPDATE`: the request wins and that `UPDATE` is discarded.
- Fetch: every cycle in which `idx` or `seg` is written generates a fetch token. This includes writes of an unchanged value, so an immediate restart to idx 0 from idx 0 still fetches. The first cycle after `RST` deasserts also generates one.
  - The token passes through a `READ_LATENCY`-deep shift register.
  - At its output: `VALUE_OUT <= MOD_BUS.VALUE`, `VALUE_VALID <= 1`.
- Reset values:
  - `idx`, `seg`, `loop_cnt`, `pend`, `pend_seg` = 0; state RUN.
  - `VALUE_OUT` = 0; `VALUE_VALID`, `STOPPED`, `SYNC_PENDING` = 0.
  - Fetch pipeline cleared.
  - `RST` mid-operation discards in-flight tokens; no `VALUE_VALID` pulse emerges from them.

## Timing
- `UPDATE` or `REQ_VALID` sampled at edge N: `idx`/`seg`/`IDX_OUT` change at N+1.
- Fetch token issued with the register write at N+1; `VALUE_VALID` at N+1+`READ_LATENCY` (N+3 by default).
- `STOPPED` asserts the cycle after the terminating `UPDATE`.
- `SYNC_PENDING` asserts the cycle after the request and deasserts with the switch.
- Throughput: one `UPDATE` per cycle is accepted. Back-to-back updates produce back-to-back `VALUE_VALID` pulses after the latency.

## Structure
- Shared in `params`: `TRANSITION_IMMEDIATE`, `TRANSITION_SYNC`, `MOD_REP_INFINITE = 16'hFFFF`, `MOD_READ_LATENCY = 2`.
- One sub-module: `mod_fetch_pipe`, a parameterised valid shift register with synchronous clear.
- The state enum stays local.

## Test plan
- Free-run: reset, `CYCLE_0 = 3`, `REP_0 = FFFF`, `UPDATE` every cycle → `IDX_OUT` 0,1,2,3,0,1…; `VALUE_VALID` every cycle from cycle 3 on; `VALUE_OUT` equals preloaded BRAM data at the matching lag.
- Repeat stop: `CYCLE_0 = 1`, `REP_0 = 1`, 6 updates → `IDX_OUT` 0,1,0,1, then held at 1; `STOPPED = 1` after the 4th update. An immediate request to seg 1 clears `STOPPED` and sets `IDX_OUT = 0`, `SEGMENT_OUT = 1`.
- Sync switch: running seg 0 at idx 2 with `CYCLE_0 = 5`, sync request to seg 1 → `SYNC_PENDING` high; seg 0 continues to idx 5; the next `UPDATE` gives seg 1, idx 0, `SYNC_PENDING` low.
- Collision: `REQ_VALID` (immediate, seg 1) and `UPDATE` in the same cycle at idx 7 → next cycle idx 0, seg 1; never idx 8.
- Reset mid-fetch: assert `RST` one cycle after `UPDATE` → no `VALUE_VALID` from the in-flight token. The first post-reset fetch returns seg 0, idx 0 data at cycle 3.

Source files
------------

// File: rtl/modulation_sampler_pkg.sv
// Shared constants for the modulation sampler: transition modes, the infinite-repeat
// marker and the BRAM_MOD read latency.
package modulation_sampler_pkg;

  localparam logic TransitionImmediate = 1'b0;
  localparam logic TransitionSync      = 1'b1;

  localparam logic [15:0] ModRepInfinite = 16'hFFFF;

  localparam int unsigned ModReadLatency = 2;

endpackage

// File: rtl/mod_fetch_pipe.sv
// Valid-token shift register that tracks outstanding BRAM reads; clr_i drops all
// tokens in flight.
module mod_fetch_pipe #(
  parameter int unsigned Depth = 2
) (
  input  logic bus_clk,
  input  logic clr_i,
  input  logic valid_i,
  output logic valid_o
);

  logic [Depth-1:0] stage_q;

  always_ff @(posedge bus_clk) begin
    if (clr_i) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= valid_i;
      for (int i = 1; i < Depth; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign valid_o = stage_q[Depth-1];

endmodule

// File: rtl/modulation_sampler.sv
// Walks the dual-segment modulation BRAM one sample per update strobe, handling repeat
// counting, stop, and immediate or wrap-synchronised segment switches.
module modulation_sampler
  import modulation_sampler_pkg::*;
#(
  parameter int unsigned ReadLatency = ModReadLatency
) (
  input  logic        bus_clk,
  input  logic        rst_i,
  input  logic        update_i,
  input  logic        req_valid_i,
  input  logic        req_segment_i,
  input  logic        req_mode_i,
  input  logic [14:0] cycle_0_i,
  input  logic [14:0] cycle_1_i,
  input  logic [15:0] rep_0_i,
  input  logic [15:0] rep_1_i,
  output logic [14:0] mod_idx_o,
  output logic        mod_segment_o,
  input  logic [7:0]  mod_value_i,
  output logic [7:0]  value_out_o,
  output logic        value_valid_o,
  output logic [14:0] idx_out_o,
  output logic        segment_out_o,
  output logic        stopped_o,
  output logic        sync_pending_o
);

  typedef enum logic {StRun, StStop} state_e;

  state_e      state_q, state_d;
  logic [14:0] idx_q, idx_d;
  logic        seg_q, seg_d;
  logic [15:0] loop_q, loop_d;
  logic        pend_q, pend_d;
  logic        pend_seg_q, pend_seg_d;
  logic        first_q;
  logic        addr_wr;
  logic        fetch_done;
  logic [7:0]  value_q;
  logic        value_valid_q;
  logic [14:0] cycle_cur;
  logic [15:0] rep_cur;

  assign cycle_cur = seg_q ? cycle_1_i : cycle_0_i;
  assign rep_cur   = seg_q ? rep_1_i : rep_0_i;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    seg_d      = seg_q;
    loop_d     = loop_q;
    pend_d     = pend_q;
    pend_seg_d = pend_seg_q;
    addr_wr    = 1'b0;

    // A request always takes priority; any update in the same cycle is dropped.
    if (req_valid_i) begin
      if (state_q == StStop || req_mode_i == TransitionImmediate) begin
        seg_d   = req_segment_i;
        idx_d   = '0;
        loop_d  = '0;
        pend_d  = 1'b0;
        state_d = StRun;
        addr_wr = 1'b1;
      end else begin
        pend_d     = 1'b1;
        pend_seg_d = req_segment_i;
      end
    end else if (update_i && state_q == StRun) begin
      // >= so that shrinking the cycle length while running still wraps.
      if (idx_q >= cycle_cur) begin
        if (pend_q) begin
          seg_d   = pend_seg_q;
          idx_d   = '0;
          loop_d  = '0;
          pend_d  = 1'b0;
          addr_wr = 1'b1;
        end else if (rep_cur != ModRepInfinite && loop_q == rep_cur) begin
          state_d = StStop;
        end else begin
          idx_d   = '0;
          addr_wr = 1'b1;
          if (loop_q != 16'hFFFF) begin
            loop_d = loop_q + 16'd1;
          end
        end
      end else begin
        idx_d   = idx_q + 15'd1;
        addr_wr = 1'b1;
      end
    end
  end

  always_ff @(posedge bus_clk) begin
    if (rst_i) begin
      state_q    <= StRun;
      idx_q      <= '0;
      seg_q      <= 1'b0;
      loop_q     <= '0;
      pend_q     <= 1'b0;
      pend_seg_q <= 1'b0;
      first_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      loop_q     <= loop_d;
      pend_q     <= pend_d;
      pend_seg_q <= pend_seg_d;
      first_q    <= 1'b0;
    end
  end

  mod_fetch_pipe #(
    .Depth (ReadLatency)
  ) u_fetch_pipe (
    .bus_clk (bus_clk),
    .clr_i   (rst_i),
    .valid_i (addr_wr | first_q),
    .valid_o (fetch_done)
  );

  always_ff @(posedge bus_clk) begin
    if (rst_i) begin
      value_q       <= '0;
      value_valid_q <= 1'b0;
    end else begin
      value_valid_q <= fetch_done;
      if (fetch_done) begin
        value_q <= mod_value_i;
      end
    end
  end

  assign mod_idx_o      = idx_q;
  assign mod_segment_o  = seg_q;
  assign idx_out_o      = idx_q;
  assign segment_out_o  = seg_q;
  assign value_out_o    = value_q;
  assign value_valid_o  = value_valid_q;
  assign stopped_o      = (state_q == StStop);
  assign sync_pending_o = pend_q;

endmodule

// File: tb/tb_modulation_sampler.sv
// Directed bench for modulation_sampler with a preloaded two-register-latency BRAM model.
module tb_modulation_sampler;
  import modulation_sampler_pkg::*;

  logic        bus_clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        update_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_segment_i = 1'b0;
  logic        req_mode_i = 1'b0;
  logic [14:0] cycle_0_i = 15'd3;
  logic [14:0] cycle_1_i = 15'd3;
  logic [15:0] rep_0_i = 16'hFFFF;
  logic [15:0] rep_1_i = 16'hFFFF;
  logic [14:0] mod_idx_o;
  logic        mod_segment_o;
  logic [7:0]  mod_value_i;
  logic [7:0]  value_out_o;
  logic        value_valid_o;
  logic [14:0] idx_out_o;
  logic        segment_out_o;
  logic        stopped_o;
  logic        sync_pending_o;

  int passed = 0;
  int total = 0;

  always #5 bus_clk = ~bus_clk;

  modulation_sampler dut (
    .bus_clk        (bus_clk),
    .rst_i          (rst_i),
    .update_i       (update_i),
    .req_valid_i    (req_valid_i),
    .req_segment_i  (req_segment_i),
    .req_mode_i     (req_mode_i),
    .cycle_0_i      (cycle_0_i),
    .cycle_1_i      (cycle_1_i),
    .rep_0_i        (rep_0_i),
    .rep_1_i        (rep_1_i),
    .mod_idx_o      (mod_idx_o),
    .mod_segment_o  (mod_segment_o),
    .mod_value_i    (mod_value_i),
    .value_out_o    (value_out_o),
    .value_valid_o  (value_valid_o),
    .idx_out_o      (idx_out_o),
    .segment_out_o  (segment_out_o),
    .stopped_o      (stopped_o),
    .sync_pending_o (sync_pending_o)
  );

  // Preloaded BRAM contents.
  function automatic logic [7:0] bram_data(input logic seg, input logic [14:0] idx);
    logic [7:0] d;
    d = {seg, idx[6:0]} ^ 8'h5A;
    return d;
  endfunction

  // Address registered by the DUT on one edge, data registered here on the next.
  always_ff @(posedge bus_clk) mod_value_i <= bram_data(mod_segment_o, mod_idx_o);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge bus_clk);
  endtask

  initial begin
    logic [14:0] stop_idx [6];
    logic        stop_flag [6];
    stop_idx  = '{15'd1, 15'd0, 15'd1, 15'd1, 15'd1, 15'd1};
    stop_flag = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    // Reset state
    tick();
    tick();
    chk("rst_idx", 32'(idx_out_o), 32'd0);
    chk("rst_seg", 32'(segment_out_o), 32'd0);
    chk("rst_valid", 32'(value_valid_o), 32'd0);
    chk("rst_value", 32'(value_out_o), 32'd0);
    chk("rst_stopped", 32'(stopped_o), 32'd0);
    chk("rst_pending", 32'(sync_pending_o), 32'd0);

    // Free-run: cycle 3, infinite repeats; first post-reset fetch lands at cycle 3.
    rst_i = 1'b0;
    tick();
    update_i = 1'b1;
    for (int k = 2; k <= 9; k++) begin
      tick();
      chk("free_idx", 32'(idx_out_o), 32'((k - 1) % 4));
      if (k >= 3) begin
        chk("free_valid", 32'(value_valid_o), 32'd1);
        chk("free_value", 32'(value_out_o), 32'(bram_data(1'b0, 15'((k - 3) % 4))));
      end else begin
        chk("free_valid_early", 32'(value_valid_o), 32'd0);
      end
    end
    update_i = 1'b0;

    // Repeat stop: cycle 1, two plays.
    rst_i = 1'b1;
    cycle_0_i = 15'd1;
    rep_0_i = 16'd1;
    tick();
    rst_i = 1'b0;
    update_i = 1'b1;
    for (int n = 0; n < 6; n++) begin
      tick();
      chk("stop_idx", 32'(idx_out_o), 32'(stop_idx[n]));
      chk("stop_flag", 32'(stopped_o), 32'(stop_flag[n]));
    end
    update_i = 1'b0;
    req_valid_i = 1'b1;
    req_segment_i = 1'b1;
    req_mode_i = TransitionSync;
    tick();
    req_valid_i = 1'b0;
    chk("restart_stopped", 32'(stopped_o), 32'd0);
    chk("restart_idx", 32'(idx_out_o), 32'd0);
    chk("restart_seg", 32'(segment_out_o), 32'd1);
    chk("restart_pending", 32'(sync_pending_o), 32'd0);

    // Sync switch from seg 0 at idx 2 with cycle 5.
    cycle_0_i = 15'd5;
    req_valid_i = 1'b1;
    req_segment_i = 1'b0;
    req_mode_i = TransitionImmediate;
    tick();
    req_valid_i = 1'b0;
    chk("imm_seg0", 32'(segment_out_o), 32'd0);
    update_i = 1'b1;
    tick();
    tick();
    update_i = 1'b0;
    chk("sync_pre_idx", 32'(idx_out_o), 32'd2);
    req_valid_i = 1'b1;
    req_segment_i = 1'b1;
    req_mode_i = TransitionSync;
    tick();
    req_valid_i = 1'b0;
    chk("sync_pend_set", 32'(sync_pending_o), 32'd1);
    chk("sync_hold_idx", 32'(idx_out_o), 32'd2);
    update_i = 1'b1;
    for (int n = 3; n <= 5; n++) begin
      tick();
      chk("sync_run_idx", 32'(idx_out_o), 32'(n));
      chk("sync_run_seg", 32'(segment_out_o), 32'd0);
      chk("sync_run_pend", 32'(sync_pending_o), 32'd1);
    end
    tick();
    update_i = 1'b0;
    chk("sync_sw_seg", 32'(segment_out_o), 32'd1);
    chk("sync_sw_idx", 32'(idx_out_o), 32'd0);
    chk("sync_sw_pend", 32'(sync_pending_o), 32'd0);

    // Collision at idx 7 of seg 1 (cycle 9, so 7 is not a wrap point).
    cycle_1_i = 15'd9;
    update_i = 1'b1;
    for (int n = 0; n < 7; n++) tick();
    chk("coll_pre_idx", 32'(idx_out_o), 32'd7);
    req_valid_i = 1'b1;
    req_segment_i = 1'b1;
    req_mode_i = TransitionImmediate;
    tick();
    req_valid_i = 1'b0;
    update_i = 1'b0;
    chk("coll_idx", 32'(idx_out_o), 32'd0);
    chk("coll_seg", 32'(segment_out_o), 32'd1);
    tick();
    tick();
    chk("coll_valid", 32'(value_valid_o), 32'd1);
    chk("coll_value", 32'(value_out_o), 32'(bram_data(1'b1, 15'd0)));
    tick();
    chk("coll_idle", 32'(value_valid_o), 32'd0);

    // Reset one cycle after an update discards the in-flight token.
    update_i = 1'b1;
    tick();
    update_i = 1'b0;
    rst_i = 1'b1;
    chk("rmf_idx", 32'(idx_out_o), 32'd1);
    tick();
    rst_i = 1'b0;
    chk("rmf_rst_idx", 32'(idx_out_o), 32'd0);
    chk("rmf_rst_seg", 32'(segment_out_o), 32'd0);
    chk("rmf_valid_c0", 32'(value_valid_o), 32'd0);
    tick();
    chk("rmf_valid_c1", 32'(value_valid_o), 32'd0);
    tick();
    chk("rmf_valid_c2", 32'(value_valid_o), 32'd0);
    tick();
    chk("rmf_valid_c3", 32'(value_valid_o), 32'd1);
    chk("rmf_value_c3", 32'(value_out_o), 32'(bram_data(1'b0, 15'd0)));
    tick();
    chk("rmf_valid_c4", 32'(value_valid_o), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
